decode_issue_stage: RTL and testbench

- Operand-fetch/issue stage directly upstream of the ALU.
- Accepts 32-bit instructions over a valid/ready handshake and decodes the opcode, register and immediate fields.
- Reads an internal register file and presents registered operands (r1, r2, immediate, opcode) to the ALU.
- A per-register busy scoreboard stalls issue until results pending for RAW/WAW hazards are written back from the downstream writeback path.

---
 rtl/decode_issue_stage.sv | 165 ++++++++++++++++
 tb/tb_decode_issue_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// Operand-fetch/issue stage: decodes a 32-bit instruction, reads the register file
// with writeback bypass, and stalls on RAW/WAW hazards via a per-register busy scoreboard.
module decode_issue_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_opcode,
  output logic [DATA_W-1:0] out_r1,
  output logic [DATA_W-1:0] out_r2,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_rd,
  output logic              out_wr,
  output logic              out_illegal,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d, eff_busy_s;
  logic              out_valid_q, out_valid_d, out_wr_q, out_wr_d, out_illegal_q, out_illegal_d;
  logic [4:0]        out_opcode_q, out_opcode_d;
  logic [2:0]        out_rd_q, out_rd_d;
  logic [DATA_W-1:0] out_r1_q, out_r1_d, out_r2_q, out_r2_d, out_imm_q, out_imm_d;

  logic [4:0]        opcode_s;
  logic [2:0]        rd_s, rs1_s, rs2_s;
  logic [DATA_W-1:0] imm_s, rs1_val_s, rs2_val_s;
  logic              is_imm_s, is_cmp_s, is_illegal_s, is_wr_s, hazard_s, issue_s;

  assign opcode_s     = in_instr[31:27];
  assign rd_s         = in_instr[26:24];
  assign rs1_s        = in_instr[23:21];
  assign rs2_s        = in_instr[20:18];
  assign imm_s        = in_instr[15:0];
  assign is_illegal_s = (opcode_s >= 5'd15);
  assign is_wr_s      = !is_illegal_s && !is_cmp_s;

  // Opcode class decode (immediate and compare classes overlap at 00110/00111)
  always_comb begin
    is_imm_s = 1'b0;
    is_cmp_s = 1'b0;
    case (opcode_s)
      5'd1, 5'd3: is_imm_s = 1'b1;
      5'd6, 5'd7: begin
        is_imm_s = 1'b1;
        is_cmp_s = 1'b1;
      end
      5'd5, 5'd8: is_cmp_s = 1'b1;
      default: begin
        is_imm_s = 1'b0;
        is_cmp_s = 1'b0;
      end
    endcase
  end

  // Hazard check and operand read; a same-cycle writeback releases and bypasses
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      eff_busy_s[i] = busy_q[i] & ~(wb_en && (wb_addr == 3'(i)));
    end
    hazard_s = (!is_illegal_s && eff_busy_s[rs1_s]) ||
               (!is_illegal_s && !is_imm_s && eff_busy_s[rs2_s]) ||
               (is_wr_s && eff_busy_s[rd_s]);
    if (wb_en && (wb_addr == rs1_s)) begin
      rs1_val_s = wb_data;
    end else begin
      rs1_val_s = regs_q[rs1_s];
    end
    if (wb_en && (wb_addr == rs2_s)) begin
      rs2_val_s = wb_data;
    end else begin
      rs2_val_s = regs_q[rs2_s];
    end
  end

  assign in_ready = !reset && (!out_valid_q || out_ready) && !hazard_s;
  assign issue_s  = in_valid && in_ready;

  // Next-state: register file, scoreboard (set after clear so set wins) and output bundle
  always_comb begin
    regs_d        = regs_q;
    busy_d        = busy_q;
    out_valid_d   = out_valid_q;
    out_opcode_d  = out_opcode_q;
    out_r1_d      = out_r1_q;
    out_r2_d      = out_r2_q;
    out_imm_d     = out_imm_q;
    out_rd_d      = out_rd_q;
    out_wr_d      = out_wr_q;
    out_illegal_d = out_illegal_q;
    if (wb_en) begin
      regs_d[wb_addr] = wb_data;
      busy_d[wb_addr] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue_s) begin
      out_valid_d   = 1'b1;
      out_opcode_d  = opcode_s;
      out_r1_d      = rs1_val_s;
      out_r2_d      = is_imm_s ? {DATA_W{1'b0}} : rs2_val_s;
      out_imm_d     = is_imm_s ? imm_s : {DATA_W{1'b0}};
      out_rd_d      = rd_s;
      out_wr_d      = is_wr_s;
      out_illegal_d = is_illegal_s;
      if (is_wr_s) begin
        busy_d[rd_s] = 1'b1;
      end else begin
        busy_d[rd_s] = busy_d[rd_s];
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      busy_q        <= {NREGS{1'b0}};
      out_valid_q   <= 1'b0;
      out_opcode_q  <= 5'd0;
      out_r1_q      <= {DATA_W{1'b0}};
      out_r2_q      <= {DATA_W{1'b0}};
      out_imm_q     <= {DATA_W{1'b0}};
      out_rd_q      <= 3'd0;
      out_wr_q      <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      out_opcode_q  <= out_opcode_d;
      out_r1_q      <= out_r1_d;
      out_r2_q      <= out_r2_d;
      out_imm_q     <= out_imm_d;
      out_rd_q      <= out_rd_d;
      out_wr_q      <= out_wr_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_opcode  = out_opcode_q;
  assign out_r1      = out_r1_q;
  assign out_r2      = out_r2_q;
  assign out_imm     = out_imm_q;
  assign out_rd      = out_rd_q;
  assign out_wr      = out_wr_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: hazards, bypass, backpressure, illegal ops, reset.
module tb_decode_issue_stage;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [4:0]  out_opcode;
  logic [15:0] out_r1, out_r2, out_imm, wb_data;
  logic [2:0]  out_rd, wb_addr;
  logic        out_wr, out_illegal, wb_en;
  int          checks = 0;
  int          errors = 0;

  decode_issue_stage #(.DATA_W(16), .NREGS(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_r1(out_r1), .out_r2(out_r2), .out_imm(out_imm),
    .out_rd(out_rd), .out_wr(out_wr), .out_illegal(out_illegal),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [15:0] imm);
    return {op, rd, rs1, rs2, 2'b00, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'd0;
    tick(); tick();
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_opcode", out_opcode, 5'd0);
    chk("rst_r1", out_r1, 16'd0);
    chk("rst_r2", out_r2, 16'd0);
    chk("rst_imm", out_imm, 16'd0);
    chk("rst_rd", out_rd, 3'd0);
    chk("rst_wr", out_wr, 1'b0);
    chk("rst_illegal", out_illegal, 1'b0);

    reset = 1'b0; wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h1234;
    #1 chk("idle_ready", in_ready, 1'b1);
    tick();
    wb_en = 1'b0;
    in_valid = 1'b1; in_instr = mk(5'd0, 3'd3, 3'd2, 3'd2, 16'd0);
    #1 chk("add_ready", in_ready, 1'b1);
    tick();
    chk("add_valid", out_valid, 1'b1);
    chk("add_r1", out_r1, 16'h1234);
    chk("add_r2", out_r2, 16'h1234);
    chk("add_wr", out_wr, 1'b1);
    chk("add_rd", out_rd, 3'd3);
    chk("add_imm", out_imm, 16'd0);

    // RAW on r3
    in_instr = mk(5'd2, 3'd4, 3'd3, 3'd0, 16'd0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("raw_stall", in_ready, 1'b0);
      tick();
    end
    chk("raw_drain", out_valid, 1'b0);
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h00FF;
    #1 chk("raw_release", in_ready, 1'b1);
    tick();
    wb_en = 1'b0;
    chk("raw_valid", out_valid, 1'b1);
    chk("raw_r1", out_r1, 16'h00FF);
    chk("raw_rd", out_rd, 3'd4);

    // Immediate op whose rs2 field names busy r4
    in_instr = mk(5'd1, 3'd6, 3'd1, 3'd4, 16'hBEEF);
    #1 chk("imm_ready", in_ready, 1'b1);
    tick();
    chk("imm_imm", out_imm, 16'hBEEF);
    chk("imm_r2", out_r2, 16'd0);
    chk("imm_wr", out_wr, 1'b1);
    chk("imm_opcode", out_opcode, 5'd1);

    // Compare with busy rd r6
    in_instr = mk(5'd8, 3'd6, 3'd1, 3'd2, 16'h5555);
    #1 chk("cmp_ready", in_ready, 1'b1);
    tick();
    chk("cmp_wr", out_wr, 1'b0);
    chk("cmp_r2", out_r2, 16'h1234);
    chk("cmp_imm", out_imm, 16'd0);

    // Backpressure
    out_ready = 1'b0;
    in_instr = mk(5'd0, 3'd7, 3'd3, 3'd2, 16'd0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", in_ready, 1'b0);
      tick();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_opcode", out_opcode, 5'd8);
      chk("bp_r2", out_r2, 16'h1234);
      chk("bp_rd", out_rd, 3'd6);
    end
    out_ready = 1'b1;
    #1 chk("bp_release", in_ready, 1'b1);
    tick();
    chk("bp_new_opcode", out_opcode, 5'd0);
    chk("bp_new_rd", out_rd, 3'd7);
    chk("bp_new_r1", out_r1, 16'h00FF);
    chk("bp_new_r2", out_r2, 16'h1234);

    // Illegal op reading busy r7 fields: uses no sources, sets no busy
    in_instr = mk(5'd21, 3'd5, 3'd7, 3'd7, 16'h0042);
    #1 chk("ill_ready", in_ready, 1'b1);
    tick();
    chk("ill_flag", out_illegal, 1'b1);
    chk("ill_wr", out_wr, 1'b0);
    chk("ill_opcode", out_opcode, 5'd21);
    in_instr = mk(5'd0, 3'd5, 3'd0, 3'd0, 16'd0);
    #1 chk("ill_nobusy", in_ready, 1'b1);
    tick();
    chk("w5_illegal", out_illegal, 1'b0);
    chk("w5_rd", out_rd, 3'd5);

    // WAW on r5, then set-wins on same-cycle wb/set
    in_instr = mk(5'd2, 3'd5, 3'd0, 3'd0, 16'd0);
    for (int i = 0; i < 2; i++) begin
      #1 chk("waw_stall", in_ready, 1'b0);
      tick();
    end
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h0555;
    #1 chk("waw_release", in_ready, 1'b1);
    tick();
    wb_en = 1'b0;
    chk("waw_valid", out_valid, 1'b1);
    chk("waw_opcode", out_opcode, 5'd2);
    in_instr = mk(5'd2, 3'd1, 3'd5, 3'd0, 16'd0);
    #1 chk("setwins_stall", in_ready, 1'b0);
    tick();
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h0AAA;
    #1 chk("setwins_release", in_ready, 1'b1);
    tick();
    wb_en = 1'b0;
    chk("bypass_r1", out_r1, 16'h0AAA);

    // Reset mid-operation with r4 busy and bundle held; wb during reset ignored
    in_valid = 1'b0; reset = 1'b1;
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'hABCD;
    #1 chk("mid_rst_ready", in_ready, 1'b0);
    tick();
    reset = 1'b0; wb_en = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_r1", out_r1, 16'd0);
    chk("mid_rst_opcode", out_opcode, 5'd0);
    in_valid = 1'b1; in_instr = mk(5'd0, 3'd4, 3'd4, 3'd2, 16'd0);
    #1 chk("post_rst_ready", in_ready, 1'b1);
    tick();
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_r2", out_r2, 16'd0);
    in_instr = mk(5'd0, 3'd3, 3'd3, 3'd5, 16'd0);
    #1 chk("post_rst_ready2", in_ready, 1'b1);
    tick();
    chk("post_rst_r3", out_r1, 16'd0);
    chk("post_rst_r5", out_r2, 16'd0);
    in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
